// File: rtl/lif_neuron_step_pkg.sv
// snn_fixed_pkg: shared sign-magnitude Q16.16 types, constants and LIF FSM states
package snn_fixed_pkg;
  localparam int N = 32;
  localparam int Q = 16;
  typedef logic [N-1:0] fixed_t;
  localparam fixed_t FX_ZERO = 32'h0000_0000;
  localparam fixed_t FX_ONE = 32'h0001_0000;
  localparam fixed_t FX_NEG_ONE = 32'h8001_0000;
  localparam fixed_t FX_V_INIT = 32'h8041_0000;
  typedef enum logic [2:0] {IDLE, DIFF, LEAK, DRIVE, SUM1, SUM2, CMP, DONE} lif_state_t;
endpackage

// File: rtl/lif_neuron_step_if.sv
// lif_neuron_step_if: step request, configuration and result handshake of one LIF neuron
interface lif_neuron_step_if #(parameter int N = snn_fixed_pkg::N);
  logic in_valid, in_ready, out_valid, out_ready, spike, refrac_active;
  logic [N-1:0] i_syn, v_rest, v_th, v_reset, v_min, leak, gain, v_out;
  logic [7:0] refrac_steps;
  modport master (
    output in_valid, i_syn, v_rest, v_th, v_reset, v_min, leak, gain, refrac_steps, out_ready,
    input in_ready, out_valid, v_out, spike, refrac_active
  );
  modport slave (
    input in_valid, i_syn, v_rest, v_th, v_reset, v_min, leak, gain, refrac_steps, out_ready,
    output in_ready, out_valid, v_out, spike, refrac_active
  );
endinterface

// File: rtl/lif_neuron_step_fxlib.sv
// fixed-point ops library: sign-magnitude negate, add, truncating multiply and compare
module negator #(parameter int N = 32) (
  input logic [N-1:0] a,
  output logic [N-1:0] y
);
  assign y = |a[N-2:0] ? {~a[N-1], a[N-2:0]} : '0;
endmodule

module add #(parameter int N = 32) (
  input logic [N-1:0] a,
  input logic [N-1:0] b,
  output logic [N-1:0] y
);
  logic same, a_ge;
  logic [N-2:0] mag;
  assign same = a[N-1] == b[N-1];
  assign a_ge = a[N-2:0] >= b[N-2:0];
  assign mag = same ? a[N-2:0] + b[N-2:0] : a_ge ? a[N-2:0] - b[N-2:0] : b[N-2:0] - a[N-2:0];
  assign y = |mag ? {(same || a_ge) ? a[N-1] : b[N-1], mag} : '0;
endmodule

module mult #(parameter int N = 32, parameter int Q = 16) (
  input logic [N-1:0] a,
  input logic [N-1:0] b,
  output logic [N-1:0] y
);
  localparam int W = 2 * N - 2;
  logic [N-2:0] mag;
  assign mag = (N-1)'((W'(a[N-2:0]) * W'(b[N-2:0])) >> Q);
  assign y = |mag ? {a[N-1] ^ b[N-1], mag} : '0;
endmodule

module fixed_point_cmp #(parameter int N = 32) (
  input logic [N-1:0] a,
  input logic [N-1:0] b,
  output logic gt,
  output logic eq,
  output logic lt
);
  logic [N-1:0] na, nb;
  assign na = |a[N-2:0] ? a : '0;
  assign nb = |b[N-2:0] ? b : '0;
  assign eq = na == nb;
  assign gt = na[N-1] != nb[N-1] ? nb[N-1] : na[N-1] ? na[N-2:0] < nb[N-2:0] : na[N-2:0] > nb[N-2:0];
  assign lt = !gt && !eq;
endmodule

// File: rtl/lif_neuron_step.sv
// lif_neuron_step: time-multiplexed leaky integrate-and-fire membrane update for one neuron
module lif_neuron_step #(
  parameter int N = snn_fixed_pkg::N,
  parameter int Q = snn_fixed_pkg::Q,
  parameter logic [N-1:0] V_INIT = snn_fixed_pkg::FX_V_INIT
) (
  input logic clk,
  input logic rst_n,
  lif_neuron_step_if.slave io
);
  import snn_fixed_pkg::*;
  lif_state_t state;
  logic [N-1:0] v, t, u, i_syn_s, v_rest_s, v_th_s, v_reset_s, v_min_s, leak_s, gain_s;
  logic [N-1:0] neg_y, add_a, add_b, add_y, mul_a, mul_b, mul_y, cmp_a, cmp_b;
  logic [7:0] rc, refrac_s;
  logic below, out_valid, spike, refrac_active, cmp_gt, cmp_eq, cmp_lt;
  assign io.in_ready = state == IDLE;
  assign io.out_valid = out_valid;
  assign io.v_out = v;
  assign io.spike = spike;
  assign io.refrac_active = refrac_active;
  negator #(.N(N)) u_neg (.a(v), .y(neg_y));
  add #(.N(N)) u_add (.a(add_a), .b(add_b), .y(add_y));
  mult #(.N(N), .Q(Q)) u_mult (.a(mul_a), .b(mul_b), .y(mul_y));
  fixed_point_cmp #(.N(N)) u_cmp (.a(cmp_a), .b(cmp_b), .gt(cmp_gt), .eq(cmp_eq), .lt(cmp_lt));
  // steer the shared operators; the floor test runs in SUM2 so CMP only needs the threshold test
  always_comb begin
    add_a = state == DIFF ? v_rest_s : state == SUM1 ? t : v;
    add_b = state == DIFF ? neg_y : state == SUM1 ? u : t;
    mul_a = state == LEAK ? leak_s : gain_s;
    mul_b = state == LEAK ? t : i_syn_s;
    cmp_a = state == SUM2 ? add_y : t;
    cmp_b = state == SUM2 ? v_min_s : v_th_s;
  end
  // step sequencer, shadow capture, membrane state and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      v <= V_INIT;
      rc <= '0;
      t <= '0;
      u <= '0;
      below <= 1'b0;
      out_valid <= 1'b0;
      spike <= 1'b0;
      refrac_active <= 1'b0;
      i_syn_s <= '0;
      v_rest_s <= '0;
      v_th_s <= '0;
      v_reset_s <= '0;
      v_min_s <= '0;
      leak_s <= '0;
      gain_s <= '0;
      refrac_s <= '0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          i_syn_s <= io.i_syn;
          v_rest_s <= io.v_rest;
          v_th_s <= io.v_th;
          v_reset_s <= io.v_reset;
          v_min_s <= io.v_min;
          leak_s <= io.leak;
          gain_s <= io.gain;
          refrac_s <= io.refrac_steps;
          if (rc != 8'd0) begin
            v <= io.v_reset;
            rc <= rc - 8'd1;
            spike <= 1'b0;
            refrac_active <= 1'b1;
            out_valid <= 1'b1;
            state <= DONE;
          end else state <= DIFF;
        end
        DIFF: begin t <= add_y; state <= LEAK; end
        LEAK: begin t <= mul_y; state <= DRIVE; end
        DRIVE: begin u <= mul_y; state <= SUM1; end
        SUM1: begin t <= add_y; state <= SUM2; end
        SUM2: begin t <= add_y; below <= cmp_lt; state <= CMP; end
        CMP: begin
          spike <= cmp_gt || cmp_eq;
          v <= (cmp_gt || cmp_eq) ? v_reset_s : below ? v_min_s : t;
          if (cmp_gt || cmp_eq) rc <= refrac_s;
          refrac_active <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (io.out_ready) begin out_valid <= 1'b0; state <= IDLE; end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_neuron_step.sv
// tb_lif_neuron_step: scoreboard bench for the LIF membrane-update stage
module tb_lif_neuron_step;
  typedef struct packed { logic [31:0] v; logic sp; logic rf; int lat; } exp_t;
  localparam logic [31:0] M65 = 32'h8041_0000, M50 = 32'h8032_0000, M70 = 32'h8046_0000;
  localparam logic [31:0] M80 = 32'h8050_0000, ONE = 32'h0001_0000, LK = 32'h0000_199A;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  exp_t sb[$];
  lif_neuron_step_if #(.N(32)) io();
  lif_neuron_step dut(.clk(clk), .rst_n(rst_n), .io(io.slave));
  always #5 clk = ~clk;

  task automatic set_cfg(input logic [31:0] rest, th, vr, vmin, lk, gn, input logic [7:0] rs);
    io.v_rest = rest; io.v_th = th; io.v_reset = vr; io.v_min = vmin;
    io.leak = lk; io.gain = gn; io.refrac_steps = rs;
  endtask

  task automatic apply_reset;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // one step with out_ready high; lat = cycle (1-based after accept) in which out_valid is seen, 0 on timeout
  task automatic run_step(input logic [31:0] i, output logic [31:0] v, output logic sp, output logic rf, output int lat);
    int e = 0;
    @(negedge clk); io.in_valid = 1'b1; io.i_syn = i;
    @(posedge clk); #1; io.in_valid = 1'b0; io.i_syn = $urandom;
    while (!io.out_valid && e < 20) begin @(posedge clk); #1; e++; end
    lat = io.out_valid ? e + 1 : 0;
    v = io.v_out; sp = io.spike; rf = io.refrac_active;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int seen = 0;
    io.in_valid = 1'b0; io.out_ready = 1'b1; io.i_syn = '0;
    set_cfg(M65, M50, M70, M80, LK, ONE, 8'd0);
    #12;
    n_tests += 5;
    if (io.v_out !== M65) begin n_fail++; $display("FAIL rst_v_out got %h want %h", io.v_out, M65); end
    if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", io.out_valid); end
    if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", io.in_ready); end
    if (io.spike !== 1'b0) begin n_fail++; $display("FAIL rst_spike got %b want 0", io.spike); end
    if (io.refrac_active !== 1'b0) begin n_fail++; $display("FAIL rst_refrac got %b want 0", io.refrac_active); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); io.in_valid = 1'b1; io.i_syn = 32'h0010_0000;
    @(posedge clk); #1; io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready got %b want 0", io.in_ready); end
    rst_n = 1'b0;
    #1;
    n_tests += 4;
    if (io.v_out !== M65) begin n_fail++; $display("FAIL mid_rst_v_out got %h want %h", io.v_out, M65); end
    if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b want 0", io.out_valid); end
    if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 1", io.in_ready); end
    if (io.spike !== 1'b0) begin n_fail++; $display("FAIL mid_rst_spike got %b want 0", io.spike); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (io.out_valid) seen++; end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL mid_rst_discard got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_equilibrium;
    exp_t e;
    logic [31:0] v; logic sp, rf; int lat;
    set_cfg(M65, M50, M70, M80, LK, ONE, 8'd0);
    sb.push_back('{M65, 1'b0, 1'b0, 7});
    run_step(32'h0, v, sp, rf, lat);
    e = sb.pop_front();
    n_tests += 4;
    if (v !== e.v) begin n_fail++; $display("FAIL eq_v got %h want %h", v, e.v); end
    if (sp !== e.sp) begin n_fail++; $display("FAIL eq_spike got %b want %b", sp, e.sp); end
    if (rf !== e.rf) begin n_fail++; $display("FAIL eq_refrac got %b want %b", rf, e.rf); end
    if (lat !== e.lat) begin n_fail++; $display("FAIL eq_latency got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_drive_leak;
    logic [31:0] ins [2] = '{32'h0002_0000, 32'h0};
    logic [31:0] want [2] = '{32'h803F_0000, 32'h803F_3334};
    exp_t e;
    logic [31:0] v; logic sp, rf; int lat;
    set_cfg(M65, M50, M70, M80, LK, ONE, 8'd0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{want[k], 1'b0, 1'b0, 7});
      run_step(ins[k], v, sp, rf, lat);
      e = sb.pop_front();
      n_tests += 4;
      if (v !== e.v) begin n_fail++; $display("FAIL drive_v[%0d] got %h want %h", k, v, e.v); end
      if (sp !== e.sp) begin n_fail++; $display("FAIL drive_spike[%0d] got %b want %b", k, sp, e.sp); end
      if (rf !== e.rf) begin n_fail++; $display("FAIL drive_refrac[%0d] got %b want %b", k, rf, e.rf); end
      if (lat !== e.lat) begin n_fail++; $display("FAIL drive_latency[%0d] got %0d want %0d", k, lat, e.lat); end
    end
  endtask

  task automatic test_threshold_refrac;
    logic [31:0] ins [4] = '{32'h000F_0000, 32'h0064_0000, 32'h0064_0000, 32'h0001_0000};
    exp_t want [4] = '{'{M70, 1'b1, 1'b0, 7}, '{M70, 1'b0, 1'b1, 1}, '{M70, 1'b0, 1'b1, 1}, '{32'h8045_0000, 1'b0, 1'b0, 7}};
    exp_t e;
    logic [31:0] v; logic sp, rf; int lat;
    apply_reset();
    set_cfg(M65, M50, M70, M80, 32'h0, ONE, 8'd2);
    for (int k = 0; k < 4; k++) begin
      sb.push_back(want[k]);
      run_step(ins[k], v, sp, rf, lat);
      e = sb.pop_front();
      n_tests += 4;
      if (v !== e.v) begin n_fail++; $display("FAIL thr_v[%0d] got %h want %h", k, v, e.v); end
      if (sp !== e.sp) begin n_fail++; $display("FAIL thr_spike[%0d] got %b want %b", k, sp, e.sp); end
      if (rf !== e.rf) begin n_fail++; $display("FAIL thr_refrac[%0d] got %b want %b", k, rf, e.rf); end
      if (lat !== e.lat) begin n_fail++; $display("FAIL thr_latency[%0d] got %0d want %0d", k, lat, e.lat); end
    end
  endtask

  task automatic test_floor_clamp;
    exp_t e;
    logic [31:0] v; logic sp, rf; int lat;
    apply_reset();
    set_cfg(M65, M50, M70, M80, 32'h0, ONE, 8'd0);
    sb.push_back('{M80, 1'b0, 1'b0, 7});
    run_step(32'h8064_0000, v, sp, rf, lat);
    e = sb.pop_front();
    n_tests += 4;
    if (v !== e.v) begin n_fail++; $display("FAIL floor_v got %h want %h", v, e.v); end
    if (sp !== e.sp) begin n_fail++; $display("FAIL floor_spike got %b want %b", sp, e.sp); end
    if (rf !== e.rf) begin n_fail++; $display("FAIL floor_refrac got %b want %b", rf, e.rf); end
    if (lat !== e.lat) begin n_fail++; $display("FAIL floor_latency got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int n = 0;
    set_cfg(M65, M50, M70, M80, 32'h0, ONE, 8'd0);
    io.out_ready = 1'b0;
    sb.push_back('{32'h804B_0000, 1'b0, 1'b0, 7});
    @(negedge clk); io.in_valid = 1'b1; io.i_syn = 32'h0005_0000;
    @(posedge clk); #1; io.in_valid = 1'b0;
    while (!io.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    n_tests++;
    if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout out_valid got %b want 1", io.out_valid); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_tests += 4;
      if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got %b want 1", k, io.out_valid); end
      if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, io.in_ready); end
      if (io.v_out !== e.v) begin n_fail++; $display("FAIL bp_v[%0d] got %h want %h", k, io.v_out, e.v); end
      if (io.spike !== e.sp) begin n_fail++; $display("FAIL bp_spike[%0d] got %b want %b", k, io.spike, e.sp); end
    end
    @(negedge clk); io.out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests += 3;
    if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", io.in_ready); end
    if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", io.out_valid); end
    if (io.v_out !== e.v) begin n_fail++; $display("FAIL bp_release_v got %h want %h", io.v_out, e.v); end
  endtask

  initial begin
    test_reset();
    test_equilibrium();
    test_drive_leak();
    test_threshold_refrac();
    test_floor_clamp();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
